data_mem_arbiter: RTL



---
 rtl/data_mem_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/data_mem_arbiter.sv
// Shares one single-port data RAM between the processor and a host/debug port; the CPU wins except
// after WAIT_MAX blocked cycles, when the CPU is stalled for one cycle. Define ARB_STATS_EN for counters.
module data_mem_arbiter #(
  parameter int BITS      = 16,
  parameter int DTBITS    = 11,
  parameter int WAIT_MAX  = 8,
  parameter int WCNT_BITS = 4
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [DTBITS-1:0] i_cpu_addr,
  input  logic [BITS-1:0]   i_cpu_data,
  input  logic              i_cpu_wr,
  input  logic              i_cpu_rd,
  output logic [BITS-1:0]   o_cpu_data,
  output logic              o_cpu_stall,
  input  logic              i_host_req,
  input  logic              i_host_we,
  input  logic [DTBITS-1:0] i_host_addr,
  input  logic [BITS-1:0]   i_host_data,
  output logic              o_host_busy,
  output logic              o_host_ack,
  output logic [BITS-1:0]   o_host_data,
  output logic [DTBITS-1:0] o_ram_addr,
  output logic [BITS-1:0]   o_ram_data,
  output logic              o_ram_wr,
  output logic              o_ram_rd,
  input  logic [BITS-1:0]   i_ram_data,
  output logic [1:0]        o_dbg_state
`ifdef ARB_STATS_EN
  ,
  output logic [BITS-1:0]   o_stall_cnt,
  output logic [BITS-1:0]   o_host_cnt
`endif
);

  // Host handshake: a request is taken only while o_host_busy is low; o_host_busy stays high
  // from the cycle after capture through the single o_host_ack cycle; o_host_data is valid from ack.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    STALL = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam logic [WCNT_BITS-1:0] WAIT_LAST = WCNT_BITS'(WAIT_MAX - 1);

  state_t                state;
  logic [WCNT_BITS-1:0]  wait_cnt;
  logic                  h_we;
  logic [DTBITS-1:0]     h_addr;
  logic [BITS-1:0]       h_data;
  logic                  cpu_busy;
  logic                  host_grant;

  assign cpu_busy    = i_cpu_wr | i_cpu_rd;
  assign host_grant  = (state == STALL) || ((state == PEND) && !cpu_busy);
  assign o_cpu_data  = i_ram_data;
  assign o_dbg_state = state;

  always_comb begin
    o_ram_addr = i_cpu_addr;
    o_ram_data = i_cpu_data;
    o_ram_wr   = i_cpu_wr;
    o_ram_rd   = i_cpu_rd;
    if (host_grant) begin
      o_ram_addr = h_addr;
      o_ram_data = h_data;
      o_ram_wr   = h_we;
      o_ram_rd   = !h_we;
    end
    // No RAM strobes leave the block while reset is held, whoever owns the port.
    if (i_reset) begin
      o_ram_wr = 1'b0;
      o_ram_rd = 1'b0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      o_host_busy <= 1'b0;
      o_host_ack  <= 1'b0;
      o_cpu_stall <= 1'b0;
      o_host_data <= '0;
      h_we        <= 1'b0;
      h_addr      <= '0;
      h_data      <= '0;
    end else begin
      o_host_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (i_host_req) begin
            h_we        <= i_host_we;
            h_addr      <= i_host_addr;
            h_data      <= i_host_data;
            wait_cnt    <= '0;
            o_host_busy <= 1'b1;
            state       <= PEND;
          end
        end
        PEND: begin
          if (!cpu_busy) begin
            if (!h_we) o_host_data <= i_ram_data;
            o_host_ack <= 1'b1;
            state      <= ACK;
          end else if (wait_cnt == WAIT_LAST) begin
            o_cpu_stall <= 1'b1;
            state       <= STALL;
          end else begin
            wait_cnt <= wait_cnt + WCNT_BITS'(1);
          end
        end
        STALL: begin
          if (!h_we) o_host_data <= i_ram_data;
          o_cpu_stall <= 1'b0;
          o_host_ack  <= 1'b1;
          state       <= ACK;
        end
        ACK: begin
          o_host_busy <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_stall_cnt <= '0;
      o_host_cnt  <= '0;
    end else begin
      if ((state == STALL) && !(&o_stall_cnt)) o_stall_cnt <= o_stall_cnt + BITS'(1);
      if ((state == ACK) && !(&o_host_cnt))    o_host_cnt  <= o_host_cnt + BITS'(1);
    end
  end
`endif

endmodule
